instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch-side consumer of the 32-word instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the returned instruction into an IF/ID pipeline register with a valid bit.
- Handles stall, flush, branch/jump redirect and out-of-range or misaligned fetch faults for the pipelined CPU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 32, instruction memory depth in words; the last legal fetch address is 4*IMEM_WORDS-4 (0x7C at default).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_addr  output  32  byte address to instruction memory; always equals pc.
imem_instr  input  32  instruction word from memory, combinational on imem_addr.
stall  input  1  hazard unit: hold PC and IF/ID.
flush  input  1  invalidate IF/ID contents at next edge.
branch_taken  input  1  branch resolved taken (EX stage).
branch_target  input  32  branch destination byte address.
jump  input  1  jump decoded (ID stage).
jump_target  input  32  jump destination byte address.
pc  output  32  current fetch PC.
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_instr  output  32  latched instruction.
if_id_pc  output  32  PC of latched instruction.
if_id_pc_plus4  output  32  if_id_pc + 4.
fetch_fault  output  1  sticky fault flag.

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_PC; state = BOOT.
  - if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; if_id_pc_plus4 = 0; fetch_fault = 0.
- State machine:
  - BOOT: exactly one cycle after reset release. No capture into IF/ID (valid stays 0) and pc holds. Next state is RUN.
  - RUN: normal fetch, per the priority rules below.
  - HALT: entered on fault. pc frozen, if_id_valid = 0, all inputs ignored. Exit only by reset.
- RUN next-state priority, evaluated each rising edge, highest first:
  1. Fault: pc > 4*IMEM_WORDS-4, or pc[1:0] != 0.
     - fetch_fault <= 1; if_id_valid <= 0; if_id_instr <= 0; state <= HALT.
     - The faulting fetch is never marked valid.
  2. Redirect: branch_taken or jump.
     - Target is branch_target if branch_taken, otherwise jump_target. Branch wins when both are asserted, because it belongs to the older instruction.
     - pc <= target; if_id_valid <= 0. Redirect overrides stall.
  3. Stall: pc and all IF/ID registers hold.
     - If flush is also asserted, if_id_valid <= 0 and the other IF/ID fields hold.
  4. Flush (no stall): pc <= pc+4; if_id_valid <= 0.
  5. Normal:
     - pc <= pc+4.
     - if_id_instr <= imem_instr; if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
- Fault on a redirect target is detected on the cycle the target is fetched, not on the redirect cycle.
- Latency:
  - An instruction at address A appears in IF/ID one edge after pc == A, absent stall or redirect.
  - Redirect costs one bubble.
- Arithmetic: pc+4 is a 32-bit wrap-around add. Wrap from 0xFFFFFFFC to 0 cannot occur in practice because the range fault halts fetch first.
- imem_addr is combinational from the pc register only, with no path from any input.
- When if_id_valid = 0, downstream treats if_id_instr as a bubble. if_id_instr is cleared to 0 only on fault.
- Reset asserted mid-stall, mid-redirect or in HALT returns all outputs to their reset values immediately.

Decomposition:
- Shared CPU package:
  - word width 32;
  - PC_STEP = 4;
  - NOP encoding 32'h0;
  - fetch state enum {BOOT, RUN, HALT} as a 2-bit type.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold, clear and load controls.
- Next-PC selection, the fault check and the FSM stay in the top.

Test Plan:
- Reset release, memory holding 0x2001_0005 at 0x0 and 0x2002_0007 at 0x4:
  - BOOT cycle has if_id_valid=0.
  - Next edge gives if_id_instr=0x20010005, if_id_pc=0, if_id_pc_plus4=4, valid=1.
  - Following edge gives 0x20020007 with if_id_pc=4.
- Stall held 3 cycles at pc=0x8:
  - pc stays 0x8 and IF/ID is unchanged for 3 cycles.
  - The first edge after release captures memory[2].
- branch_taken=1, branch_target=0x40 and jump=1, jump_target=0x10 in the same cycle, with stall=1:
  - pc=0x40 and if_id_valid=0 next edge.
  - Next capture has if_id_pc=0x40.
- flush pulse with stall=0 at pc=0xC:
  - if_id_valid=0 and pc=0x10.
  - Next edge gives valid=1 with if_id_pc=0x10.
- Sequential run to pc=0x80:
  - 0x7C is captured valid.
  - On the 0x80 edge, fetch_fault=1, state HALT, valid=0.
  - pc stays 0x80 despite jump pulses.
  - Reset clears fetch_fault.
- jump_target=0x22 (misaligned):
  - Redirect edge gives pc=0x22, valid=0.
  - Next edge gives fetch_fault=1, valid=0.
- Async reset asserted mid-cycle in RUN: all outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch unit and its IF/ID register.
package instruction_fetch_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // A fetch address is illegal if it lies past the last memory word or is not word aligned.
  function automatic logic pc_is_illegal(input logic [WORD_W-1:0] pc,
                                         input logic [WORD_W-1:0] last_pc);
    return (pc > last_pc) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Clear wipes valid and the instruction. Load captures a new instruction and marks it valid.
// Kill drops only the valid bit so the other fields keep their contents.
// When no control is asserted, every field holds its value.
module instruction_fetch_unit_if_id_reg
  import instruction_fetch_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_kill,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_pc_plus4,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_pc_plus4
);

  logic              r_valid;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_pc_plus4;

  // Update the IF/ID fields. Clear has the highest priority, then load, then kill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// This block owns the PC and drives the instruction memory address.
// It selects the next PC, detects out-of-range or misaligned fetches, and
// sequences BOOT, RUN and HALT around the IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  output logic [31:0] o_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc_plus4,
  output logic        o_fetch_fault
);

  localparam logic [WORD_W-1:0] LAST_PC = WORD_W'(4 * IMEM_WORDS - 4);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_next_pc;
  logic              r_fetch_fault;
  logic              w_set_fault;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_redirect_target;
  logic              w_redirect;
  logic              w_fault;
  logic              w_load;
  logic              w_kill;
  logic              w_clear;

  assign w_pc_plus4        = r_pc + PC_STEP;
  assign w_fault           = pc_is_illegal(r_pc, LAST_PC);
  assign w_redirect        = i_branch_taken | i_jump;
  assign w_redirect_target = i_branch_taken ? i_branch_target : i_jump_target;

  // Register the FSM state, the PC and the sticky fault flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_set_fault) begin
        r_fetch_fault <= 1'b1;
      end
    end
  end

  // Compute the next state, the next PC and the IF/ID controls. Priority in RUN is fault, redirect, stall, flush, then normal fetch.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_set_fault  = 1'b0;
    w_load       = 1'b0;
    w_kill       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_fault) begin
          w_set_fault  = 1'b1;
          w_clear      = 1'b1;
          w_next_state = ST_HALT;
        end else if (w_redirect) begin
          w_next_pc = w_redirect_target;
          w_kill    = 1'b1;
        end else if (i_stall) begin
          w_kill = i_flush;
        end else if (i_flush) begin
          w_next_pc = w_pc_plus4;
          w_kill    = 1'b1;
        end else begin
          w_next_pc = w_pc_plus4;
          w_load    = 1'b1;
        end
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_HALT;
        w_clear      = 1'b1;
      end
    endcase
  end

  instruction_fetch_unit_if_id_reg u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_kill     (w_kill),
    .i_instr    (i_imem_instr),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_valid    (o_if_id_valid),
    .o_instr    (o_if_id_instr),
    .o_pc       (o_if_id_pc),
    .o_pc_plus4 (o_if_id_pc_plus4)
  );

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// It models a 32-word instruction memory and applies a table of per-cycle vectors.
// It then runs hand-written reset and fault sequences and a scoreboarded run with random stalls.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic [31:0] pc;
  logic        ifIdValid;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdPcPlus4;
  logic        fetchFault;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] mem [32];

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expIfPc;
    logic [31:0] expPc4;
    logic [31:0] expInstr;
    logic        expFault;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs [20];
  sb_t  sbQ [$];

  instruction_fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .o_imem_addr      (imemAddr),
    .i_imem_instr     (imemInstr),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_branch_taken   (branchTaken),
    .i_branch_target  (branchTarget),
    .i_jump           (jump),
    .i_jump_target    (jumpTarget),
    .o_pc             (pc),
    .o_if_id_valid    (ifIdValid),
    .o_if_id_instr    (ifIdInstr),
    .o_if_id_pc       (ifIdPc),
    .o_if_id_pc_plus4 (ifIdPcPlus4),
    .o_fetch_fault    (fetchFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory that returns all ones outside the legal range.
  always_comb begin
    imemInstr = 32'hFFFF_FFFF;
    if (imemAddr < 32'h80) imemInstr = mem[imemAddr[6:2]];
  end

  // Stop a hung run after a generous time limit.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt);
    stall        = s;
    flush        = f;
    branchTaken  = b;
    branchTarget = bt;
    jump         = j;
    jumpTarget   = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput($sformatf("%s.pc", tag), pc, 32'h0);
    checkOutput($sformatf("%s.imemAddr", tag), imemAddr, 32'h0);
    checkOutput($sformatf("%s.valid", tag), {31'b0, ifIdValid}, 32'h0);
    checkOutput($sformatf("%s.instr", tag), ifIdInstr, 32'h0);
    checkOutput($sformatf("%s.ifPc", tag), ifIdPc, 32'h0);
    checkOutput($sformatf("%s.pc4", tag), ifIdPcPlus4, 32'h0);
    checkOutput($sformatf("%s.fault", tag), {31'b0, fetchFault}, 32'h0);
  endtask

  function automatic vec_t mkVec(input logic s, input logic f, input logic b, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic [31:0] ePc,
                                 input logic eV, input logic [31:0] eIfPc, input logic [31:0] ePc4,
                                 input logic [31:0] eInstr, input logic eF);
    vec_t v;
    v.stall = s; v.flush = f; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
    v.expPc = ePc; v.expValid = eV; v.expIfPc = eIfPc; v.expPc4 = ePc4;
    v.expInstr = eInstr; v.expFault = eF;
    return v;
  endfunction

  initial begin
    logic [31:0] expPc;
    logic        s;
    sb_t         e;

    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0007;

    vecs[0]  = mkVec(0,0,0,32'h0, 0,32'h0,  32'h00,0,32'h00,32'h00,32'h0,        0);
    vecs[1]  = mkVec(0,0,0,32'h0, 0,32'h0,  32'h04,1,32'h00,32'h04,32'h2001_0005,0);
    vecs[2]  = mkVec(0,0,0,32'h0, 0,32'h0,  32'h08,1,32'h04,32'h08,32'h2002_0007,0);
    vecs[3]  = mkVec(1,0,0,32'h0, 0,32'h0,  32'h08,1,32'h04,32'h08,32'h2002_0007,0);
    vecs[4]  = mkVec(1,0,0,32'h0, 0,32'h0,  32'h08,1,32'h04,32'h08,32'h2002_0007,0);
    vecs[5]  = mkVec(1,0,0,32'h0, 0,32'h0,  32'h08,1,32'h04,32'h08,32'h2002_0007,0);
    vecs[6]  = mkVec(0,0,0,32'h0, 0,32'h0,  32'h0C,1,32'h08,32'h0C,32'hA000_0002,0);
    vecs[7]  = mkVec(0,1,0,32'h0, 0,32'h0,  32'h10,0,32'h08,32'h0C,32'hA000_0002,0);
    vecs[8]  = mkVec(0,0,0,32'h0, 0,32'h0,  32'h14,1,32'h10,32'h14,32'hA000_0004,0);
    vecs[9]  = mkVec(1,0,1,32'h40,1,32'h10, 32'h40,0,32'h10,32'h14,32'hA000_0004,0);
    vecs[10] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h44,1,32'h40,32'h44,32'hA000_0010,0);
    vecs[11] = mkVec(1,1,0,32'h0, 0,32'h0,  32'h44,0,32'h40,32'h44,32'hA000_0010,0);
    vecs[12] = mkVec(0,0,0,32'h0, 1,32'h70, 32'h70,0,32'h40,32'h44,32'hA000_0010,0);
    vecs[13] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h74,1,32'h70,32'h74,32'hA000_001C,0);
    vecs[14] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h78,1,32'h74,32'h78,32'hA000_001D,0);
    vecs[15] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h7C,1,32'h78,32'h7C,32'hA000_001E,0);
    vecs[16] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h80,1,32'h7C,32'h80,32'hA000_001F,0);
    vecs[17] = mkVec(0,0,0,32'h0, 0,32'h0,  32'h80,0,32'h7C,32'h80,32'h0,        1);
    vecs[18] = mkVec(0,0,0,32'h0, 1,32'h10, 32'h80,0,32'h7C,32'h80,32'h0,        1);
    vecs[19] = mkVec(1,1,1,32'h0, 0,32'h0,  32'h80,0,32'h7C,32'h80,32'h0,        1);

    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    rstN = 1'b0;
    #12;
    checkReset("reset");
    rstN = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt);
      tick();
      checkOutput($sformatf("v%0d.pc", i), pc, vecs[i].expPc);
      checkOutput($sformatf("v%0d.imemAddr", i), imemAddr, vecs[i].expPc);
      checkOutput($sformatf("v%0d.valid", i), {31'b0, ifIdValid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("v%0d.ifPc", i), ifIdPc, vecs[i].expIfPc);
      checkOutput($sformatf("v%0d.pc4", i), ifIdPcPlus4, vecs[i].expPc4);
      checkOutput($sformatf("v%0d.instr", i), ifIdInstr, vecs[i].expInstr);
      checkOutput($sformatf("v%0d.fault", i), {31'b0, fetchFault}, {31'b0, vecs[i].expFault});
    end

    #3;
    rstN = 1'b0;
    #1;
    checkReset("haltRst");
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    tick();
    checkOutput("mis.bootPc", pc, 32'h0);
    tick();
    checkOutput("mis.firstPc", pc, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 1, 32'h22);
    tick();
    checkOutput("mis.redirPc", pc, 32'h22);
    checkOutput("mis.redirValid", {31'b0, ifIdValid}, 32'h0);
    checkOutput("mis.redirFault", {31'b0, fetchFault}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("mis.fault", {31'b0, fetchFault}, 32'h1);
    checkOutput("mis.valid", {31'b0, ifIdValid}, 32'h0);
    checkOutput("mis.pc", pc, 32'h22);
    checkOutput("mis.instr", ifIdInstr, 32'h0);

    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkReset("misRst");
    @(negedge clk);
    rstN = 1'b1;
    tick();

    expPc = 32'h0;
    for (int c = 0; c < 24; c++) begin
      s = ($urandom_range(0, 3) == 0);
      applyStimulus(s, 0, 0, 32'h0, 0, 32'h0);
      if (!s) begin
        sbQ.push_back({expPc, mem[expPc[6:2]]});
        expPc = expPc + 32'd4;
      end
      tick();
      checkOutput($sformatf("sb%0d.pc", c), pc, expPc);
      if (!s) begin
        checkOutput($sformatf("sb%0d.valid", c), {31'b0, ifIdValid}, 32'h1);
        if (ifIdValid && sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput($sformatf("sb%0d.ifPc", c), ifIdPc, e.pc);
          checkOutput($sformatf("sb%0d.pc4", c), ifIdPcPlus4, e.pc + 32'd4);
          checkOutput($sformatf("sb%0d.instr", c), ifIdInstr, e.instr);
        end
      end
    end
    checkOutput("sb.queueEmpty", sbQ.size(), 32'h0);

    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("runRst.preValid", {31'b0, ifIdValid}, 32'h1);
    #3;
    rstN = 1'b0;
    #1;
    checkReset("runRst");
    #5;
    rstN = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
